// File: rtl/mfp_uart_tx_if.sv
// CPU-side write/status bundle for the UART transmitter.
// The master drives bytes and clears; the slave (transmitter) reports FIFO and line status.
interface mfp_uart_tx_if;
  logic [7:0] tx_wdata;
  logic       tx_we;
  logic       tx_ovf_clr;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_busy;
  logic       tx_overflow;

  modport master (
    output tx_wdata, tx_we, tx_ovf_clr,
    input  tx_full, tx_empty, tx_busy, tx_overflow
  );

  modport slave (
    input  tx_wdata, tx_we, tx_ovf_clr,
    output tx_full, tx_empty, tx_busy, tx_overflow
  );
endinterface

// File: rtl/mfp_uart_tx.sv
// 8N1 UART transmitter with a small transmit FIFO, fixed baud from CLKS_PER_BIT.
// Frames are sent back-to-back whenever the FIFO holds data at the end of a stop bit.
module mfp_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic          SI_ClkIn,
  input  logic          SI_Reset_N,
  mfp_uart_tx_if.slave  tx_if,
  output logic          UART_TX
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH  = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          overflow;

  state_t        state, state_n;
  logic [CW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          line_n;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  // Full is judged on the current count, so a write is dropped even if a pop frees a slot this cycle.
  assign push  = tx_if.tx_we && !full;

  always_ff @(posedge SI_ClkIn) begin
    if (!SI_Reset_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (!push && pop)
        count <= count - 1'b1;
      if (tx_if.tx_we && full)
        overflow <= 1'b1;
      else if (tx_if.tx_ovf_clr)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge SI_ClkIn) begin
    if (push) mem[wr_ptr] <= tx_if.tx_wdata;
  end

  always_ff @(posedge SI_ClkIn) begin
    if (!SI_Reset_N) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      UART_TX <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      UART_TX <= line_n;
    end
  end

  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          baud_n  = RELOAD;
          state_n = START;
        end
      end
      START: begin
        if (baud == '0) begin
          baud_n    = RELOAD;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      DATA: begin
        if (baud == '0) begin
          shift_n = {1'b0, shift[7:1]};
          baud_n  = RELOAD;
          if (bit_idx == 3'd7)
            state_n = STOP;
          else
            bit_idx_n = bit_idx + 1'b1;
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      STOP: begin
        if (baud == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            baud_n  = RELOAD;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level follows the state being entered so UART_TX stays a clean register output.
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shift_n[0];
      default: line_n = 1'b1;
    endcase
  end

  assign tx_if.tx_full     = full;
  assign tx_if.tx_empty    = empty;
  assign tx_if.tx_busy     = !empty || (state != IDLE);
  assign tx_if.tx_overflow = overflow;

endmodule
